// File: rtl/pga_spi_master.sv
// pga_spi_master: serial gain-code writer for chip-selected PGAs with per-channel shadow readback
module pga_spi_master #(
  parameter int DATA_W = 8,
  parameter int N_CH = 1,
  parameter int HOLDOFF = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] RESET_CODE = '0,
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic                     sck,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        code_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic                     bcast_i,
  input  logic                     set_i,
  output logic                     ready_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [N_CH*DATA_W-1:0]   gain_o,
  output logic [N_CH-1:0]          cs_n,
  output logic                     sdo
);
  localparam int CNT_W = $clog2((DATA_W > HOLDOFF ? DATA_W : HOLDOFF) + 1);
  localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d, code_q, code_d;
  logic [N_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH*DATA_W-1:0] gain_q, gain_d;
  logic done_q, done_d, err_q, err_d, acc, bad;
  assign ready_o = state_q == IDLE && !rst;
  assign acc = set_i && ready_o;
  assign bad = !bcast_i && {1'b0, ch_i} >= N_CH_L;
  assign done_o = done_q;
  assign err_o = err_q;
  assign gain_o = gain_q;
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    code_d = code_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    gain_d = gain_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      err_d = acc && bad;
      if (acc && !bad) begin
        state_d = SHIFT;
        sreg_d = code_i;
        code_d = code_i;
        mask_d = bcast_i ? '1 : N_CH'(1) << ch_i;
        cnt_d = '0;
      end
    end else if (state_q == SHIFT) begin
      sreg_d = MSB_FIRST ? sreg_q << 1 : sreg_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        state_d = HOLD;
        cnt_d = '0;
        done_d = 1'b1;
        for (int k = 0; k < N_CH; k++)
          gain_d[k*DATA_W +: DATA_W] = mask_q[k] ? code_q : gain_q[k*DATA_W +: DATA_W];
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CNT_W'(HOLDOFF - 1) ? IDLE : HOLD;
    end
  end
  always_ff @(posedge sck) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q <= '0;
      code_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      gain_q <= {N_CH{RESET_CODE}};
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      code_q <= code_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      gain_q <= gain_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  always_ff @(negedge sck) begin
    cs_n <= rst || state_q != SHIFT ? '1 : ~mask_q;
    sdo <= !rst && state_q == SHIFT && (MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0]);
  end
endmodule

// File: tb/tb_pga_spi_master.sv
// tb_pga_spi_master: scoreboard bench for pga_spi_master
module tb_pga_spi_master;
  typedef struct packed {logic is_err; logic [7:0] code; logic [3:0] mask;} exp_t;
  logic sck = 1'b0, rst = 1'b1;
  logic [7:0] code0 = '0;
  logic [1:0] ch0 = '0;
  logic bc0 = 1'b0, set0 = 1'b0;
  logic rdy0, done0, err0, sdo0;
  logic [23:0] gain0;
  logic [2:0] cs0;
  logic [5:0] code1 = '0;
  logic [1:0] ch1 = '0;
  logic bc1 = 1'b0, set1 = 1'b0;
  logic rdy1, done1, err1, sdo1;
  logic [23:0] gain1;
  logic [3:0] cs1;
  int total = 0, bad = 0, cyc = 0;
  exp_t sb0[$], sb1[$];
  exp_t e0, e1;
  logic [7:0] sh0[3];
  logic [5:0] sh1[4];
  logic [7:0] fr0;
  logic [5:0] fr1;
  int nb0 = 0, nb1 = 0;
  logic [2:0] fcs0, xcs0;
  logic [3:0] fcs1, xcs1;
  logic unst0, unst1;
  logic b2b = 1'b0;
  int last_done0 = -1;

  pga_spi_master #(.DATA_W(8), .N_CH(3), .HOLDOFF(2), .MSB_FIRST(1'b1), .RESET_CODE(8'h5A)) u0 (
    .sck(sck), .rst(rst), .code_i(code0), .ch_i(ch0), .bcast_i(bc0), .set_i(set0),
    .ready_o(rdy0), .done_o(done0), .err_o(err0), .gain_o(gain0), .cs_n(cs0), .sdo(sdo0));

  pga_spi_master #(.DATA_W(6), .N_CH(4), .HOLDOFF(1), .MSB_FIRST(1'b0), .RESET_CODE(6'h00)) u1 (
    .sck(sck), .rst(rst), .code_i(code1), .ch_i(ch1), .bcast_i(bc1), .set_i(set1),
    .ready_o(rdy1), .done_o(done1), .err_o(err1), .gain_o(gain1), .cs_n(cs1), .sdo(sdo1));

  always #5 sck = ~sck;
  always @(posedge sck) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge sck) begin
    if (rst) nb0 = 0;
    else if (cs0 != 3'b111) begin
      if (nb0 == 0) begin
        fcs0 = cs0;
        unst0 = 1'b0;
      end else if (cs0 != fcs0) unst0 = 1'b1;
      fr0 = {fr0[6:0], sdo0};
      nb0++;
    end
    if (rst) nb1 = 0;
    else if (cs1 != 4'b1111) begin
      if (nb1 == 0) begin
        fcs1 = cs1;
        unst1 = 1'b0;
      end else if (cs1 != fcs1) unst1 = 1'b1;
      if (nb1 < 6) fr1[nb1] = sdo1;
      nb1++;
    end
  end

  always @(negedge sck) begin
    if (done0 || err0) begin
      chk("sb0_pending", sb0.size() > 0, 1);
      if (sb0.size() > 0) begin
        e0 = sb0.pop_front();
        chk("kind0", {done0, err0}, e0.is_err ? 2'b01 : 2'b10);
        if (!e0.is_err) begin
          for (int k = 0; k < 3; k++) if (e0.mask[k]) sh0[k] = e0.code;
          xcs0 = ~e0.mask[2:0];
          chk("bits0", fr0, e0.code);
          chk("nbits0", nb0, 8);
          chk("cs0", fcs0, xcs0);
          chk("cs_stable0", unst0, 0);
          if (b2b) begin
            if (last_done0 >= 0) chk("spacing0", cyc - last_done0, 11);
            last_done0 = cyc;
          end
        end
        chk("gain0", gain0, {sh0[2], sh0[1], sh0[0]});
      end
      nb0 = 0;
    end
    if (done1 || err1) begin
      chk("sb1_pending", sb1.size() > 0, 1);
      if (sb1.size() > 0) begin
        e1 = sb1.pop_front();
        for (int k = 0; k < 4; k++) if (e1.mask[k]) sh1[k] = e1.code[5:0];
        xcs1 = ~e1.mask;
        chk("kind1", {done1, err1}, 2'b10);
        chk("bits1", fr1, e1.code[5:0]);
        chk("nbits1", nb1, 6);
        chk("cs1", fcs1, xcs1);
        chk("cs_stable1", unst1, 0);
        chk("gain1", gain1, {sh1[3], sh1[2], sh1[1], sh1[0]});
      end
      nb1 = 0;
    end
  end

  task automatic send0(input logic [7:0] c, input logic [1:0] ch, input logic bc, input logic drop);
    int n = 0;
    code0 = c;
    ch0 = ch;
    bc0 = bc;
    set0 = 1'b1;
    while (!rdy0 && n < 40) begin
      @(negedge sck);
      n++;
    end
    chk("accept0", n < 40, 1);
    if (n < 40) sb0.push_back('{is_err: !bc && ch >= 2'd3, code: c, mask: bc ? 4'b0111 : 4'(1) << ch});
    @(negedge sck);
    if (drop) set0 = 1'b0;
  endtask

  task automatic send1(input logic [5:0] c, input logic [1:0] ch, input logic bc);
    int n = 0;
    code1 = c;
    ch1 = ch;
    bc1 = bc;
    set1 = 1'b1;
    while (!rdy1 && n < 40) begin
      @(negedge sck);
      n++;
    end
    chk("accept1", n < 40, 1);
    if (n < 40) sb1.push_back('{is_err: 1'b0, code: {2'b00, c}, mask: bc ? 4'b1111 : 4'(1) << ch});
    @(negedge sck);
    set1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 100) begin
      @(negedge sck);
      n++;
    end
    chk("drain", sb0.size() + sb1.size(), 0);
    repeat (2) @(negedge sck);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) sh0[k] = 8'h5A;
    for (int k = 0; k < 4; k++) sh1[k] = 6'h00;
    repeat (3) @(negedge sck);
    #1;
    chk("rst_ready0", rdy0, 0);
    chk("rst_cs0", cs0, 3'b111);
    chk("rst_sdo0", sdo0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_gain0", gain0, 24'h5A5A5A);
    chk("rst_cs1", cs1, 4'b1111);
    chk("rst_gain1", gain1, 24'h000000);
    @(negedge sck);
    rst = 1'b0;
    @(posedge sck);
    #1 chk("ready_after_rst0", rdy0, 1);
    @(negedge sck);
    send0(8'hA5, 2'd1, 1'b0, 1'b1);
    drain();
    send1(6'h3C, 2'd0, 1'b1);
    drain();
    send1(6'h21, 2'd2, 1'b0);
    drain();
    send0(8'h3C, 2'd0, 1'b1, 1'b1);
    drain();
    send0(8'h00, 2'd0, 1'b0, 1'b1);
    drain();
    send0(8'hFF, 2'd2, 1'b0, 1'b1);
    drain();
    send0(8'h77, 2'd3, 1'b0, 1'b1);
    chk("ready_during_err0", rdy0, 1);
    drain();
    chk("ready_after_err0", rdy0, 1);
    b2b = 1'b1;
    last_done0 = -1;
    send0(8'h11, 2'd0, 1'b0, 1'b0);
    send0(8'h22, 2'd1, 1'b0, 1'b0);
    send0(8'h33, 2'd2, 1'b0, 1'b1);
    drain();
    b2b = 1'b0;
    send0(8'hC3, 2'd0, 1'b0, 1'b1);
    repeat (3) @(negedge sck);
    rst = 1'b1;
    sb0.delete();
    for (int k = 0; k < 3; k++) sh0[k] = 8'h5A;
    for (int k = 0; k < 4; k++) sh1[k] = 6'h00;
    @(posedge sck);
    #1 chk("ready_in_rst0", rdy0, 0);
    @(negedge sck);
    #1;
    chk("cs_after_rst0", cs0, 3'b111);
    chk("sdo_after_rst0", sdo0, 0);
    chk("gain_after_rst0", gain0, 24'h5A5A5A);
    chk("gain_after_rst1", gain1, 24'h000000);
    @(negedge sck);
    rst = 1'b0;
    @(posedge sck);
    #1 chk("ready_rst_drop0", rdy0, 1);
    repeat (15) @(negedge sck);
    send0(8'h81, 2'd2, 1'b0, 1'b1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
